debruijn_checker: RTL and testbench

Downstream consumer of the 4-bit de Bruijn sequence generator. Samples the generator's `state` bus on each slow-clock tick and checks that every new sample is a legal successor of the previous one. Confirms that one full period visits all 16 states exactly once, and counts errors. Used as on-chip self-test for the generator and as a lock indicator for logic that consumes the sequence.

---
 rtl/debruijn_pkg.sv | 19 +
 rtl/debruijn_visit_map.sv | 47 ++++
 rtl/debruijn_checker.sv | 149 ++++++++++++++
 tb/tb_debruijn_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/debruijn_pkg.sv
// debruijn_pkg: shared constants, FSM state type and generator feedback
// function for the 4-bit de Bruijn sequence checker.
package debruijn_pkg;

  localparam int unsigned DB_W      = 4;
  localparam int unsigned DB_PERIOD = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } db_state_e;

  // Generator feedback: shift right, new bit 3 = s1 ^ s0 ^ ~(s3|s2|s1).
  // The NOR term inserts the all-zero state into the 15-state LFSR cycle.
  function automatic logic [DB_W-1:0] db_next(input logic [DB_W-1:0] s);
    return {s[1] ^ s[0] ^ ~(s[3] | s[2] | s[1]), s[3:1]};
  endfunction

endpackage

// File: rtl/debruijn_visit_map.sv
// debruijn_visit_map: 16-entry visited-state bitmap.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears the map)
//   clear     - clear the whole map this cycle
//   set_en    - set bit[set_idx] this cycle (applied after clear)
//   set_idx   - index to mark as visited
//   test_idx  - index to look up
//   test_hit  - registered bit[test_idx]
//   all_set   - every state has been visited
module debruijn_visit_map
  import debruijn_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            set_en,
  input  logic [DB_W-1:0] set_idx,
  input  logic [DB_W-1:0] test_idx,
  output logic            test_hit,
  output logic            all_set
);

  logic [DB_PERIOD-1:0] map_q;
  logic [DB_PERIOD-1:0] map_d;

  always_comb begin
    map_d = map_q;
    if (clear) begin
      map_d = '0;
    end
    if (set_en) begin
      map_d[set_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map_q <= '0;
    end else begin
      map_q <= map_d;
    end
  end

  assign test_hit = map_q[test_idx];
  assign all_set  = &map_q;

endmodule

// File: rtl/debruijn_checker.sv
// debruijn_checker: checks the sampled 4-bit de Bruijn generator state for
// legal successors and full-period coverage, reports lock and errors.
// Ports:
//   clk, rst     - fast clock, synchronous active-high reset
//   valid        - one-cycle strobe for a new generator sample
//   sel          - generator seed-load select; holds the checker in IDLE
//   state_in     - generator state, bit 3 newest
//   locked       - RUN with a completed period and no error since sync
//   period_done  - pulse on a complete 16-state period
//   seq_err      - pulse on any violation
//   period_len   - sample count of the last completed period
//   err_count    - saturating error count (ERR_W bits)
// Optional: define DEBRUIJN_FEEDBACK_CHECK_EN to also check the exact
// generator feedback law on every RUN sample.
module debruijn_checker
  import debruijn_pkg::*;
#(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             sel,
  input  logic [3:0]       state_in,
  output logic             locked,
  output logic             period_done,
  output logic             seq_err,
  output logic [4:0]       period_len,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [4:0] PERIOD_CNT = 5'(DB_PERIOD);

  db_state_e        state_q, state_d;
  logic [3:0]       start_q, start_d;
  logic [3:0]       prev_q, prev_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             period_done_q, period_done_d;
  logic             seq_err_q, seq_err_d;
  logic [4:0]       period_len_q, period_len_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic map_clear, map_set, map_hit, map_full;
  logic shift_ok, fb_ok, is_ret, err;

  debruijn_visit_map u_map (
    .clk      (clk),
    .rst      (rst),
    .clear    (map_clear),
    .set_en   (map_set),
    .set_idx  (state_in),
    .test_idx (state_in),
    .test_hit (map_hit),
    .all_set  (map_full)
  );

  always_comb begin
    shift_ok = (state_in[2:0] == prev_q[3:1]);
    is_ret   = (state_in == start_q);
`ifdef DEBRUIJN_FEEDBACK_CHECK_EN
    fb_ok    = (state_in == db_next(prev_q));
`else
    fb_ok    = 1'b1;
`endif
    err = !shift_ok || !fb_ok || (map_hit && !is_ret) ||
          (is_ret && !((cnt_q == PERIOD_CNT) && map_full));
  end

  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    prev_d        = prev_q;
    cnt_d         = cnt_q;
    locked_d      = locked_q;
    period_done_d = 1'b0;
    seq_err_d     = 1'b0;
    period_len_d  = period_len_q;
    err_count_d   = err_count_q;
    map_clear     = 1'b0;
    map_set       = 1'b0;

    if (sel) begin
      state_d   = ST_IDLE;
      map_clear = 1'b1;
      cnt_d     = '0;
      locked_d  = 1'b0;
    end else if (valid) begin
      // Sync, error resync and completed return all restart coverage from
      // the current sample; only the reporting differs.
      if (state_q == ST_IDLE || err || is_ret) begin
        start_d   = state_in;
        prev_d    = state_in;
        map_clear = 1'b1;
        map_set   = 1'b1;
        cnt_d     = 5'd1;
        state_d   = ST_RUN;
        if (state_q == ST_RUN) begin
          if (err) begin
            seq_err_d = 1'b1;
            locked_d  = 1'b0;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
          end else begin
            period_done_d = 1'b1;
            period_len_d  = cnt_q;
            locked_d      = 1'b1;
          end
        end
      end else begin
        map_set = 1'b1;
        cnt_d   = cnt_q + 5'd1;
        prev_d  = state_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      start_q       <= '0;
      prev_q        <= '0;
      cnt_q         <= '0;
      locked_q      <= 1'b0;
      period_done_q <= 1'b0;
      seq_err_q     <= 1'b0;
      period_len_q  <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      locked_q      <= locked_d;
      period_done_q <= period_done_d;
      seq_err_q     <= seq_err_d;
      period_len_q  <= period_len_d;
      err_count_q   <= err_count_d;
    end
  end

  assign locked      = locked_q;
  assign period_done = period_done_q;
  assign seq_err     = seq_err_q;
  assign period_len  = period_len_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_debruijn_checker.sv
module tb_debruijn_checker;

  logic       clk = 1'b0;
  logic       rst, valid, sel;
  logic [3:0] state_in;
  logic       locked, period_done, seq_err;
  logic [4:0] period_len;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  debruijn_checker #(.ERR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid),
    .sel         (sel),
    .state_in    (state_in),
    .locked      (locked),
    .period_done (period_done),
    .seq_err     (seq_err),
    .period_len  (period_len),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Canonical generator period starting at seed 1000, derived by hand.
  logic [3:0] seq [16] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001,
                           4'b1100, 4'b0110, 4'b1011, 4'b0101,
                           4'b1010, 4'b1101, 4'b1110, 4'b1111,
                           4'b0111, 4'b0011, 4'b0001, 4'b0000};

  // Reference model: list of samples since the last sync.
  bit         m_run = 1'b0;
  logic [3:0] m_q[$];
  logic       exp_locked = 1'b0, exp_pd = 1'b0, exp_err = 1'b0;
  logic [4:0] exp_plen = '0;
  int         exp_ecnt = 0;

  function automatic logic [3:0] seq_succ(input logic [3:0] s);
    for (int i = 0; i < 16; i++)
      if (seq[i] == s) return seq[(i + 1) % 16];
    return 4'bxxxx;
  endfunction

  always @(posedge clk) begin
    logic [3:0] prv, strt;
    bit bad, seen;
    exp_pd  = 1'b0;
    exp_err = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_q.delete();
      exp_locked = 1'b0; exp_plen = '0; exp_ecnt = 0;
    end else if (sel) begin
      m_run = 1'b0; m_q.delete();
      exp_locked = 1'b0;
    end else if (valid) begin
      if (!m_run) begin
        m_run = 1'b1;
        m_q = {state_in};
      end else begin
        prv  = m_q[m_q.size() - 1];
        strt = m_q[0];
        bad  = (state_in[2:0] != prv[3:1]);
`ifdef DEBRUIJN_FEEDBACK_CHECK_EN
        if (state_in != seq_succ(prv)) bad = 1'b1;
`endif
        seen = 1'b0;
        foreach (m_q[i]) if (m_q[i] == state_in) seen = 1'b1;
        if (state_in == strt) begin
          if (m_q.size() != 16) bad = 1'b1;
        end else if (seen) begin
          bad = 1'b1;
        end
        if (bad) begin
          exp_err = 1'b1;
          exp_locked = 1'b0;
          if (exp_ecnt < 255) exp_ecnt++;
          m_q = {state_in};
        end else if (state_in == strt) begin
          exp_pd = 1'b1;
          exp_plen = 5'(m_q.size());
          exp_locked = 1'b1;
          m_q = {state_in};
        end else begin
          m_q.push_back(state_in);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("locked", int'(locked), int'(exp_locked));
      check("period_done", int'(period_done), int'(exp_pd));
      check("seq_err", int'(seq_err), int'(exp_err));
      check("period_len", int'(period_len), int'(exp_plen));
      check("err_count", int'(err_count), exp_ecnt);
    end
  end

  task automatic put(input logic [3:0] s);
    @(negedge clk); #1;
    valid = 1'b1; state_in = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      valid = 1'b0;
    end
  endtask

  task automatic sel_pulse(input int n);
    @(negedge clk); #1;
    sel = 1'b1; valid = 1'b0;
    for (int i = 1; i < n; i++) begin
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic feed_period(input int k);
    for (int i = 0; i < 16; i++) put(seq[(k + i) % 16]);
    put(seq[k]);
  endtask

  int ecnt_snap;

  initial begin
    rst = 1'b1; valid = 1'b0; sel = 1'b0; state_in = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_locked", int'(locked), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_period_len", int'(period_len), 0);

    // Full legal period from seed 1000, back to 1000 on the 17th sample.
    feed_period(0);
    idle(1);
    check("p1_done", int'(period_done), 1);
    check("p1_len", int'(period_len), 16);
    check("p1_locked", int'(locked), 1);
    check("p1_err_count", int'(err_count), 0);

    // Shift mismatch 1000 -> 0110, then relock from 0110.
    put(4'b0110);
    idle(1);
    check("inj_err", int'(seq_err), 1);
    check("inj_err_count", int'(err_count), 1);
    check("inj_locked", int'(locked), 0);
    for (int i = 1; i < 16; i++) put(seq[(5 + i) % 16]);
    put(4'b0110);
    idle(1);
    check("relock_done", int'(period_done), 1);
    check("relock_locked", int'(locked), 1);

    // Early return to start after 4 samples.
    sel_pulse(1);
    put(4'b1000); put(4'b0100); put(4'b0010); put(4'b0001); put(4'b1000);
    idle(1);
    check("short_err", int'(seq_err), 1);
    check("short_done", int'(period_done), 0);

    // 0000 -> 0000 repeat.
    sel_pulse(1);
    put(4'b0000); put(4'b0000);
    idle(1);
    check("zero_rep_err", int'(seq_err), 1);

    // sel mid-period for 3 cycles with valid also high, resume from 0101.
    sel_pulse(1);
    for (int i = 0; i < 5; i++) put(seq[i]);
    @(negedge clk); #1;
    sel = 1'b1; valid = 1'b1; state_in = 4'b1111;
    ecnt_snap = exp_ecnt;
    idle(0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    sel = 1'b0; valid = 1'b0;
    feed_period(7);
    idle(1);
    check("sel_done", int'(period_done), 1);
    check("sel_len", int'(period_len), 16);
    check("sel_err_count", int'(err_count), ecnt_snap);

    // 300 forced errors: each repeated 0000 returns to start too early.
    sel_pulse(1);
    for (int i = 0; i < 301; i++) put(4'b0000);
    idle(1);
    check("sat_err_count", int'(err_count), 255);

    // Relock, then reset in the same cycle as valid.
    sel_pulse(1);
    feed_period(0);
    idle(1);
    check("pre_rst_locked", int'(locked), 1);
    @(negedge clk); #1;
    rst = 1'b1; valid = 1'b1; state_in = 4'b0100;
    @(negedge clk); #1;
    check("rstv_locked", int'(locked), 0);
    check("rstv_done", int'(period_done), 0);
    check("rstv_err", int'(seq_err), 0);
    check("rstv_len", int'(period_len), 0);
    check("rstv_err_count", int'(err_count), 0);
    rst = 1'b0; valid = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
